// File: rtl/multicycle_controller.sv
// Multicycle RV32I control unit: a registered FSM that sequences fetch, decode,
// execute, memory and writeback, stalls on mem_ready, traps illegal opcodes and counts retirements.
module multicycle_controller #(
  parameter bit EN_LUI   = 1'b1,
  parameter bit MEM_WAIT = 1'b1,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       op_code,
  input  logic             zero,
  input  logic             mem_ready,
  input  logic             trap_clr,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_w,
  output logic             ir_write,
  output logic             reg_w,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [2:0]       imm_src,
  output logic             illegal,
  output logic [CNT_W-1:0] retire_cnt
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADR   = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXEC_R    = 4'd6;
  localparam logic [3:0] S_EXEC_I    = 4'd7;
  localparam logic [3:0] S_LUI       = 4'd8;
  localparam logic [3:0] S_JAL       = 4'd9;
  localparam logic [3:0] S_ALU_WB    = 4'd10;
  localparam logic [3:0] S_BEQ       = 4'd11;
  localparam logic [3:0] S_TRAP      = 4'd12;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             rdy;
  logic             pc_update, branch, retire;
  logic             ir_w, mem_w_s, reg_w_s;

  assign rdy = MEM_WAIT ? mem_ready : 1'b1;

  // NOTE: every signal written here gets a default first, so no path leaves a value held and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    adr_src    = 1'b0;
    ir_w       = 1'b0;
    mem_w_s    = 1'b0;
    reg_w_s    = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    pc_update  = 1'b0;
    branch     = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_w       = rdy;
        pc_update  = rdy;
        if (rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op_code)
          OP_LW, OP_SW: state_d = S_MEM_ADR;
          OP_R:         state_d = S_EXEC_R;
          OP_I:         state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          OP_LUI:       state_d = EN_LUI ? S_LUI : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op_code == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        adr_src = 1'b1;
        if (rdy) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        result_src = 2'b01;
        reg_w_s    = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WRITE: begin
        adr_src = 1'b1;
        mem_w_s = 1'b1;
        if (rdy) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = S_ALU_WB;
      end
      S_LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = S_ALU_WB;
      end
      S_JAL: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_w_s = 1'b1;
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_BEQ: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_TRAP: begin
        if (trap_clr) state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (op_code)
      OP_SW:   imm_src = 3'b001;
      OP_BEQ:  imm_src = 3'b010;
      OP_JAL:  imm_src = 3'b011;
      OP_LUI:  imm_src = 3'b100;
      default: imm_src = 3'b000;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (retire) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Enables are gated by rst_n so they drop the instant reset asserts, not at the next edge.
  assign pc_write   = rst_n & (pc_update | (branch & zero));
  assign ir_write   = rst_n & ir_w;
  assign mem_w      = rst_n & mem_w_s;
  assign reg_w      = rst_n & reg_w_s;
  assign illegal    = (state_q == S_TRAP);
  assign retire_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: per-instruction cycle plans built from the opcode rules,
// replayed with random stalls on a default instance (a) and an EN_LUI=0, CNT_W=4 instance (b).
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op_code = 7'b0110011;
  logic       zero = 1'b0, mem_ready = 1'b1, trap_clr = 1'b0;

  logic       a_pcw, a_adr, a_mw, a_irw, a_rw, a_ill;
  logic [1:0] a_rs, a_sa, a_sb, a_aop;
  logic [2:0] a_imm;
  logic [31:0] a_cnt;
  logic       b_pcw, b_adr, b_mw, b_irw, b_rw, b_ill;
  logic [1:0] b_rs, b_sa, b_sb, b_aop;
  logic [2:0] b_imm;
  logic [3:0] b_cnt;

  multicycle_controller dut_a (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
    .trap_clr(trap_clr), .pc_write(a_pcw), .adr_src(a_adr), .mem_w(a_mw), .ir_write(a_irw),
    .reg_w(a_rw), .result_src(a_rs), .alu_src_a(a_sa), .alu_src_b(a_sb), .alu_op(a_aop),
    .imm_src(a_imm), .illegal(a_ill), .retire_cnt(a_cnt));

  multicycle_controller #(.EN_LUI(1'b0), .MEM_WAIT(1'b1), .CNT_W(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .zero(zero), .mem_ready(mem_ready),
    .trap_clr(trap_clr), .pc_write(b_pcw), .adr_src(b_adr), .mem_w(b_mw), .ir_write(b_irw),
    .reg_w(b_rw), .result_src(b_rs), .alu_src_a(b_sa), .alu_src_b(b_sb), .alu_op(b_aop),
    .imm_src(b_imm), .illegal(b_ill), .retire_cnt(b_cnt));

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011, IT = 7'b0010011;
  localparam logic [6:0] BQ = 7'b1100011, JL = 7'b1101111, LU = 7'b0110111, BAD = 7'b1111111;

  typedef struct packed {
    logic [6:0] op;
    logic       mr, tclr, pcu, br, adr, mw, irw, rw;
    logic [1:0] rs, sa, sb, aop;
    logic       ill, ret;
  } step_t;

  step_t      plan[$];
  logic [6:0] plan_op;
  int         model_cnt = 0;
  int         force_zero = -1;
  int         checks = 0, errors = 0;

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      SW: return 3'b001;
      BQ: return 3'b010;
      JL: return 3'b011;
      LU: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic step_t st(input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] aop,
                               input logic [1:0] rs, input logic adr, input logic mw, input logic irw,
                               input logic rw, input logic pcu, input logic br, input logic ret,
                               input logic mr);
    step_t s;
    s = '0;
    s.op = plan_op; s.sa = sa; s.sb = sb; s.aop = aop; s.rs = rs;
    s.adr = adr; s.mw = mw; s.irw = irw; s.rw = rw; s.pcu = pcu; s.br = br; s.ret = ret; s.mr = mr;
    return s;
  endfunction

  // Expected output bundle, pc_write formed from the update/branch rule with the driven zero.
  function automatic logic [16:0] exp_vec(input step_t s, input logic z);
    return {s.pcu | (s.br & z), s.adr, s.mw, s.irw, s.rw, s.rs, s.sa, s.sb, s.aop, imm_of(s.op), s.ill};
  endfunction

  task automatic plan_trap(input int n);
    step_t s;
    for (int i = 0; i <= n; i++) begin
      s = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rb());
      s.ill = 1'b1;
      s.tclr = (i == n);
      plan.push_back(s);
    end
  endtask

  task automatic plan_instr(input logic [6:0] op, input int fstall, input int mstall, input bit en_lui);
    step_t wb;
    plan_op = op;
    wb = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, rb());
    for (int i = 0; i < fstall; i++) plan.push_back(st(0, 2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    plan.push_back(st(0, 2, 0, 2, 0, 0, 1, 0, 1, 0, 0, 1));
    plan.push_back(st(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rb()));
    case (op)
      LW: begin
        plan.push_back(st(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rb()));
        for (int i = 0; i < mstall; i++) plan.push_back(st(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        plan.push_back(st(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
        plan.push_back(st(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, rb()));
      end
      SW: begin
        plan.push_back(st(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rb()));
        for (int i = 0; i < mstall; i++) plan.push_back(st(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        plan.push_back(st(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 1));
      end
      RT: begin plan.push_back(st(2, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, rb())); plan.push_back(wb); end
      IT: begin plan.push_back(st(2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, rb())); plan.push_back(wb); end
      BQ: plan.push_back(st(2, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, rb()));
      JL: begin plan.push_back(st(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, rb())); plan.push_back(wb); end
      LU: begin
        if (en_lui) begin
          plan.push_back(st(3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, rb()));
          plan.push_back(wb);
        end
      end
      default: ;
    endcase
  endtask

  // Replays queued steps one cycle each; entered and left just after a falling edge.
  task automatic run_plan(input bit use_b, input int max_steps);
    step_t       s;
    logic        z;
    logic [16:0] act, exp;
    logic [31:0] act_cnt, exp_cnt;
    int          n = 0;
    while (plan.size() > 0 && n < max_steps) begin
      s = plan.pop_front();
      op_code = s.op; mem_ready = s.mr; trap_clr = s.tclr;
      z = (force_zero < 0) ? rb() : 1'(force_zero);
      zero = z;
      #1;
      exp = exp_vec(s, z);
      act = use_b ? {b_pcw, b_adr, b_mw, b_irw, b_rw, b_rs, b_sa, b_sb, b_aop, b_imm, b_ill}
                  : {a_pcw, a_adr, a_mw, a_irw, a_rw, a_rs, a_sa, a_sb, a_aop, a_imm, a_ill};
      checks++;
      if (act !== exp) begin
        errors++;
        $display("FAIL outputs[%s] t=%0t op=%b got=%h exp=%h", use_b ? "b" : "a", $time, s.op, act, exp);
      end
      act_cnt = use_b ? 32'(b_cnt) : a_cnt;
      exp_cnt = use_b ? 32'(model_cnt % 16) : 32'(model_cnt);
      checks++;
      if (act_cnt !== exp_cnt) begin
        errors++;
        $display("FAIL retire_cnt[%s] t=%0t got=%0d exp=%0d", use_b ? "b" : "a", $time, act_cnt, exp_cnt);
      end
      if (s.ret) model_cnt++;
      n++;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; trap_clr = 1'b0; zero = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; op_code = RT;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if ({a_pcw, a_irw, a_mw, a_rw, a_ill, a_adr, a_rs, a_sb} !== {5'b0, 1'b0, 2'b10, 2'b10}) begin
      errors++;
      $display("FAIL reset_outputs got=%b", {a_pcw, a_irw, a_mw, a_rw, a_ill, a_adr, a_rs, a_sb});
    end
    checks++;
    if (a_cnt !== 32'd0 || b_cnt !== 4'd0) begin
      errors++;
      $display("FAIL reset_cnt got a=%0d b=%0d exp=0", a_cnt, b_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
  endtask

  task automatic test_rtype();
    plan_instr(RT, 0, 0, 1'b1);
    run_plan(1'b0, 100);
    #1;
    checks++;
    if (a_cnt !== 32'd1) begin errors++; $display("FAIL rtype_retire got=%0d exp=1", a_cnt); end
  endtask

  task automatic test_load_stall();
    do_reset();
    plan_instr(LW, 0, 2, 1'b1);
    run_plan(1'b0, 100);
    plan_instr(LW, 2, 3, 1'b1);
    run_plan(1'b0, 100);
  endtask

  task automatic test_branch();
    do_reset();
    force_zero = 1; plan_instr(BQ, 0, 0, 1'b1); run_plan(1'b0, 100);
    force_zero = 0; plan_instr(BQ, 1, 0, 1'b1); run_plan(1'b0, 100);
    force_zero = -1;
    checks++;
    if (a_cnt !== 32'd2) begin errors++; $display("FAIL branch_retire got=%0d exp=2", a_cnt); end
  endtask

  task automatic test_store_jal_itype();
    do_reset();
    plan_instr(SW, 1, 2, 1'b1); run_plan(1'b0, 100);
    plan_instr(JL, 0, 0, 1'b1); run_plan(1'b0, 100);
    plan_instr(IT, 0, 0, 1'b1); run_plan(1'b0, 100);
  endtask

  task automatic test_trap();
    do_reset();
    plan_instr(RT, 0, 0, 1'b1);
    plan_instr(BAD, 0, 0, 1'b1);
    plan_trap(10);
    plan_instr(RT, 0, 0, 1'b1);
    run_plan(1'b0, 100);
  endtask

  task automatic test_lui();
    do_reset();
    plan_instr(LU, 0, 0, 1'b1); run_plan(1'b0, 100);
    do_reset();
    plan_instr(LU, 0, 0, 1'b0); plan_trap(3); plan_instr(RT, 0, 0, 1'b0);
    run_plan(1'b1, 100);
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      plan_instr(RT, $urandom_range(2, 0), 0, 1'b0);
      run_plan(1'b1, 100);
    end
    #1;
    checks++;
    if (b_cnt !== 4'd0 || a_cnt !== 32'd16) begin
      errors++;
      $display("FAIL wrap got b=%0d a=%0d exp b=0 a=16", b_cnt, a_cnt);
    end
  endtask

  task automatic test_reset_mid_write();
    plan_instr(SW, 0, 5, 1'b1);
    run_plan(1'b0, 4);
    plan.delete();
    mem_ready = 1'b0;
    #1;
    checks++;
    if (a_mw !== 1'b1) begin errors++; $display("FAIL mid_write_pre mem_w got=%b exp=1", a_mw); end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (a_mw !== 1'b0 || a_cnt !== 32'd0) begin
      errors++;
      $display("FAIL mid_write_reset got mem_w=%b cnt=%0d exp 0/0", a_mw, a_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_cnt = 0;
    plan_instr(RT, 0, 0, 1'b1);
    run_plan(1'b0, 100);
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    ops = '{LW, SW, RT, IT, BQ, JL, LU};
    do_reset();
    for (int i = 0; i < 30; i++) begin
      plan_instr(ops[$urandom_range(6, 0)], $urandom_range(3, 0), $urandom_range(3, 0), 1'b1);
      run_plan(1'b0, 100);
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_stall();
    test_branch();
    test_store_jal_itype();
    test_trap();
    test_lui();
    test_wrap();
    test_reset_mid_write();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
Parametrised multicycle control unit for the RV32I core. It replaces the single-cycle main decoder with a registered FSM that sequences fetch, decode, execute, memory and writeback over several cycles on a shared-memory datapath. It stalls on a memory-ready handshake, traps on unsupported opcodes, and counts retired instructions. It sits between the instruction register/ALU-zero flag and the multicycle datapath muxes and enables.

Parameters:
EN_LUI, 1, 1 = decode LUI (opcode 0110111); 0 = LUI is illegal
MEM_WAIT, 1, 1 = honour mem_ready; 0 = mem_ready treated as constant 1
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
op_code  in  7  opcode from instruction register
zero  in  1  ALU zero flag
mem_ready  in  1  memory access completes this cycle
trap_clr  in  1  leave TRAP state
pc_write  out  1  PC register enable
adr_src  out  1  0 = PC, 1 = ALU result register
mem_w  out  1  memory write strobe
ir_write  out  1  instruction/old-PC register enable
reg_w  out  1  register file write
result_src  out  2  00 alu_out reg, 01 mem data, 10 alu result
alu_src_a  out  2  00 PC, 01 old PC, 10 rs1, 11 zero
alu_src_b  out  2  00 rs2, 01 imm, 10 constant 4
alu_op  out  2  00 add, 01 sub, 10 funct-decoded
imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U
illegal  out  1  sticky, high while in TRAP
retire_cnt  out  CNT_W  retired-instruction count

Behaviour:
- State is registered. Outputs are Moore-decoded from state, except the mem_ready gating and the zero term in pc_write. Any output not listed for a state is 0.
- imm_src is decoded combinationally from op_code in every state: LW/I 000, SW 001, BEQ 010, JAL 011, LUI 100, others 000.
- pc_write = pc_update | (branch & zero). pc_update and branch are internal.
- Reset (rst_n low, asynchronous): state = FETCH, retire_cnt = 0, illegal = 0. While rst_n is low, pc_write, ir_write, mem_w and reg_w are forced to 0.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write and pc_update are asserted only when mem_ready is high. On mem_ready -> DECODE; otherwise stay.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - 0110111 -> LUI if EN_LUI, else TRAP
  - any other opcode -> TRAP
- MEM_ADR: alu_src_a=10, alu_src_b=01, alu_op=00. Next is MEM_READ if opcode is LW, else MEM_WRITE.
- MEM_READ: adr_src=1, result_src=00. Wait for mem_ready -> MEM_WB.
- MEM_WB: result_src=01, reg_w=1 -> FETCH. Retires.
- MEM_WRITE: adr_src=1, result_src=00, mem_w=1 held until mem_ready -> FETCH. Retires in the mem_ready cycle.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10 -> ALU_WB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10 -> ALU_WB.
- LUI: alu_src_a=11, alu_src_b=01, alu_op=00 -> ALU_WB.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1 -> ALU_WB.
- ALU_WB: result_src=00, reg_w=1 -> FETCH. Retires.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1 -> FETCH. Retires regardless of zero.
- TRAP: illegal=1 and all enables 0. Stays until trap_clr = 1, then -> FETCH with illegal cleared on that edge. Not counted as retired.
- retire_cnt increments by 1 on each retiring edge and wraps from 2^CNT_W-1 to 0.
- mem_ready is ignored in every state except FETCH, MEM_READ and MEM_WRITE.
- Reset mid-operation: abandons the instruction without retiring it, and mem_w deasserts immediately.

Test Plan:
- Reset, mem_ready=1, op_code=0110011 -> states FETCH, DECODE, EXEC_R, ALU_WB over 4 cycles; reg_w=1 only in cycle 4; retire_cnt 0->1.
- LW with mem_ready low for 2 cycles in MEM_READ -> 7 cycles; reg_w with result_src=01 in the last cycle; no ir_write while stalled.
- BEQ with zero=1 -> pc_write=1 in the BEQ cycle. BEQ with zero=0 -> pc_write=0 in the BEQ cycle. Both retire.
- op_code=1111111 -> TRAP after DECODE; illegal=1 and zero enables for 10 cycles; trap_clr pulse -> FETCH, illegal=0, retire_cnt unchanged.
- EN_LUI=0 with op_code=0110111 -> TRAP. EN_LUI=1 with the same opcode -> alu_src_a=11, imm_src=100, writeback.
- CNT_W=4: 16 R-type instructions -> retire_cnt wraps to 0. rst_n dropped mid-MEM_WRITE -> mem_w=0 asynchronously, then FETCH and retire_cnt=0.
